// File: rtl/tc_pl_acp_wr_master.sv
// AXI3 ACP write master: one BURST_LEN x 64-bit INCR burst per en/rdy request from the ACP TX sequencer.
// Optional watchdog (wr_timeout) is built only when ACP_WR_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tc_pl_acp_wr_master #(
  parameter int unsigned BURST_LEN   = 16,
  parameter logic [3:0]  AWCACHE     = 4'b1111,
  parameter logic [4:0]  AWUSER      = 5'b00001,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acp_tx_en,
  output logic        acp_tx_rdy,
  input  logic [31:0] acp_tx_awaddr,
  input  logic [2:0]  acp_tx_awid,
  input  logic [63:0] acp_tx_wdata,
  output logic        acp_tx_wdreq,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awid,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [4:0]  m_axi_awuser,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic [2:0]  m_axi_wid,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [2:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        wr_err,
  output logic [1:0]  wr_err_code,
  output logic [31:0] wr_burst_cnt,
  output logic        wr_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        wlast_q, wlast_d;
  logic        bready_q, bready_d;
  logic        rdy_q, rdy_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  id_q, id_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  beat_inc;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] cnt_q, cnt_d;

  assign beat_inc = beat_q + 4'd1;

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    bready_d   = bready_q;
    rdy_d      = 1'b0;
    addr_d     = addr_q;
    id_d       = id_q;
    beat_d     = beat_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // The rdy guard keeps a still-high en from being taken in the 2nd rdy cycle.
        if (acp_tx_en && !rdy_q) begin
          addr_d    = {acp_tx_awaddr[31:3], 3'b000};
          id_d      = acp_tx_awid;
          awvalid_d = 1'b1;
          state_d   = ST_AW;
          if (acp_tx_awaddr[6:0] != 7'd0) begin
            if (!err_q) err_code_d = 2'b00;
            err_d = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          rdy_d     = 1'b1;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (!wvalid_q) begin
          // First cycle in W: data becomes valid one cycle after the 1st rdy.
          wvalid_d = 1'b1;
          wlast_d  = (LAST_BEAT == 4'd0);
        end else if (m_axi_wready) begin
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            beat_d   = 4'd0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            beat_d  = beat_inc;
            wlast_d = (beat_inc == LAST_BEAT);
          end
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          rdy_d    = 1'b1;
          cnt_d    = cnt_q + 32'd1;
          state_d  = ST_IDLE;
          if ((m_axi_bresp != 2'b00) || (m_axi_bid != id_q)) begin
            if (!err_q) err_code_d = m_axi_bresp;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      rdy_q      <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef ACP_WR_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) > 16) ? $clog2(TIMEOUT_CYC + 1) : 16;

  logic [TW-1:0] wd_q;
  logic          timeout_q;
  logic          any_hs;

  assign any_hs = (awvalid_q & m_axi_awready) | (wvalid_q & m_axi_wready) | (bready_q & m_axi_bvalid);

  // Watchdog only flags a stall; the FSM keeps waiting so the AXI protocol is never violated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || any_hs) begin
      wd_q <= '0;
    end else if (wd_q != TW'(TIMEOUT_CYC)) begin
      wd_q <= wd_q + TW'(1);
      if (wd_q == TW'(TIMEOUT_CYC - 1)) timeout_q <= 1'b1;
    end
  end

  assign wr_timeout = timeout_q;
`else
  assign wr_timeout = 1'b0;
`endif

  assign acp_tx_rdy    = rdy_q;
  assign acp_tx_wdreq  = wvalid_q & m_axi_wready;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = AWCACHE;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awuser  = AWUSER;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = acp_tx_wdata;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wid     = id_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign wr_err        = err_q;
  assign wr_err_code   = err_code_q;
  assign wr_burst_cnt  = cnt_q;

endmodule
